// File: rtl/an_code_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : an_code_pkg
//  Description : Shared constants, FSM state type and parameter-rule check
//                for the AN-code encoder and its datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package an_code_pkg;

    localparam int AN_A    = 47;   // code constant (odd, nonzero)
    localparam int AN_A_W  = 6;    // width of the code constant
    localparam int AN_N_W  = 17;   // data word width
    localparam int AN_AN_W = 23;   // codeword width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Encodes the parameter rules. An odd A keeps every single-bit error
    // syndrome nonzero. A < 2**A_W makes sure A fits in its field.
    // AN_W == N_W + A_W is wide enough to hold the largest product.
    function automatic bit an_params_ok(input int a, input int a_w,
                                        input int n_w, input int an_w);
        return (a > 0) && ((a % 2) == 1) && (a < (1 << a_w)) &&
               (an_w == n_w + a_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/an_shift_add_dp.sv
`default_nettype none
// ============================================================================
//  Module      : an_shift_add_dp
//  Description : Shift-and-add multiplier datapath. It consumes one bit of
//                A per step, starting with the LSB.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk     in   1      clock, rising edge
//    rst_n   in   1      asynchronous active-low reset
//    load_i  in   1      start a product: mcand=n_i, mult=A, acc=0, cnt=0
//    step_i  in   1      process one multiplier bit
//    n_i     in   N_W    multiplicand (data word)
//    last_o  out  1      current step processes the final multiplier bit
//    sum_o   out  AN_W   accumulator plus the current partial product
// ============================================================================
module an_shift_add_dp
    import an_code_pkg::*;
#(
    parameter int A    = AN_A,
    parameter int A_W  = AN_A_W,
    parameter int N_W  = AN_N_W,
    parameter int AN_W = AN_AN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [N_W-1:0]  n_i,
    output logic            last_o,
    output logic [AN_W-1:0] sum_o
);

    localparam int CNT_W = (A_W > 1) ? $clog2(A_W) : 1;

    logic [AN_W-1:0]  acc_q,   acc_d;
    logic [AN_W-1:0]  mcand_q, mcand_d;
    logic [A_W-1:0]   mult_q,  mult_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [AN_W-1:0]  w_addend;

    // The partial product for the current bit is added here. sum_o therefore
    // already holds the complete product during the final step, and the
    // top level can register it on the same edge.
    assign w_addend = mult_q[0] ? mcand_q : '0;
    assign sum_o    = acc_q + w_addend;
    assign last_o   = (cnt_q == CNT_W'(A_W - 1));

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            acc_d   = '0;
            mcand_d = AN_W'(n_i);
            mult_d  = A_W'(A);
            cnt_d   = '0;
        end else if (step_i) begin
            acc_d   = sum_o;
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/an_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : an_encoder_seq
//  Description : Sequential AN-code encoder (an_out = n_in * A). It uses a
//                shift-and-add multiplier that processes one bit of A per
//                clock, with valid/ready handshakes on the input and output.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   1     clock, rising edge
//    rst_n      in   1     asynchronous active-low reset
//    n_in       in   N_W   data word to encode
//    in_valid   in   1     n_in valid
//    in_ready   out  1     encoder can accept a word (IDLE only)
//    an_out     out  AN_W  codeword N*A
//    out_valid  out  1     an_out valid
//    out_ready  in   1     downstream accepts an_out
// ============================================================================
module an_encoder_seq
    import an_code_pkg::*;
#(
    parameter int A    = AN_A,
    parameter int A_W  = AN_A_W,
    parameter int N_W  = AN_N_W,
    parameter int AN_W = AN_AN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_W-1:0]  n_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [AN_W-1:0] an_out,
    output logic            out_valid,
    input  logic            out_ready
);

    if (!an_params_ok(A, A_W, N_W, AN_W)) begin : g_param_check
        $error("an_encoder_seq: need A odd, 0 < A < 2**A_W, AN_W == N_W + A_W");
    end

    state_t          state_q, state_d;
    logic [AN_W-1:0] an_out_q, an_out_d;
    logic            out_valid_q, out_valid_d;

    logic            w_load;
    logic            w_step;
    logic            w_last;
    logic [AN_W-1:0] w_sum;

    an_shift_add_dp #(
        .A    (A),
        .A_W  (A_W),
        .N_W  (N_W),
        .AN_W (AN_W)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (w_load),
        .step_i (w_step),
        .n_i    (n_in),
        .last_o (w_last),
        .sum_o  (w_sum)
    );

    // in_ready is decoded from the registered state only. It therefore drops
    // on the accept edge and does not rise again until the cycle after the
    // output handshake.
    assign in_ready  = (state_q == IDLE);
    assign an_out    = an_out_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d     = state_q;
        an_out_d    = an_out_q;
        out_valid_d = out_valid_q;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_load  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    an_out_d    = w_sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // an_out keeps its value after the handshake. Downstream
                // logic qualifies it with out_valid.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            an_out_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            an_out_q    <= an_out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_an_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_an_encoder_seq
//  Description : Scoreboard testbench for an_encoder_seq. The driver pushes
//                the expected codeword on each accepted input. The monitor
//                pops and compares it on each output transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_an_encoder_seq;

    localparam int A    = 47;
    localparam int N_W  = 17;
    localparam int AN_W = 23;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_W-1:0]  n_in = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [AN_W-1:0] an_out;
    logic            out_valid;
    logic            out_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [AN_W-1:0] exp_q[$];
    bit   soak_done;

    an_encoder_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .n_in      (n_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .an_out    (an_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference AN decoder. Residues +-2^i mod 47 (i = 0..22) are all
    // distinct, so any single bit flip can be located from the syndrome.
    function automatic longint an_decode(input logic [AN_W-1:0] cw);
        longint v = cw;
        longint r = v % A;
        longint p;
        if (r == 0) return v / A;
        for (int i = 0; i < AN_W; i++) begin
            p = longint'(1) << i;
            if (cw[i] && ((p % A) == r)) return (v - p) / A;
            if (!cw[i] && (((A - (p % A)) % A) == r)) return (v + p) / A;
        end
        return -1;
    endfunction

    // Monitor: a transfer happens on the next posedge.
    always @(negedge clk) begin
        logic [AN_W-1:0] e;
        logic [AN_W-1:0] flipped;
        int b;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", an_out, -1);
            end else begin
                e = exp_q.pop_front();
                chk("an_out", an_out, e);
                chk("an_out_mod_A", an_out % A, 0);
                b = $urandom_range(0, AN_W - 1);
                flipped = an_out ^ (AN_W'(1) << b);
                chk("decode_flip", an_decode(flipped), e / A);
            end
        end
    end

    // Drive one word. When keep=1, the expected codeword is pushed just
    // before the accept edge.
    task automatic send(input logic [N_W-1:0] n, input bit keep);
        bit done = 0;
        in_valid = 1'b1;
        n_in     = n;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                if (keep) exp_q.push_back(AN_W'(n * A));
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    // Send a word with out_ready=1 and measure the latency to out_valid.
    task automatic send_timed(input logic [N_W-1:0] n, input string name);
        int lat = -1;
        out_ready = 1'b1;
        send(n, 1);
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat = i;
        end
        chk({name, "_latency"}, lat, 6);
        chk({name, "_in_ready_busy"}, in_ready, 0);
        @(posedge clk); #1;
        chk({name, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        // 1. Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_an_out", an_out, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("idle_no_valid", seen, 0);

        // 2 and 3. Basic and corner words
        send_timed(17'd1213, "n1213");
        chk("const_57011", 1213 * 47, 57011);
        send_timed(17'd0, "n0");
        send_timed(17'd1, "n1");
        send_timed(17'd131071, "nmax");

        // 4. Backpressure
        out_ready = 1'b0;
        send(17'd100, 1);
        seen = 0;
        for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            n_in     = 17'd7;
            @(negedge clk);
            if (!(out_valid && an_out == 23'd4700 && !in_ready)) seen++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("backpressure_hold", seen, 0);
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("bp_single_transfer", exp_q.size(), 0);
        chk("bp_out_valid_low", out_valid, 0);

        // 5. Reset during CALC
        send(17'd9, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        send(17'd5, 1);
        repeat (15) @(posedge clk);
        #1;
        chk("midrst_one_output", exp_q.size(), 0);
        chk("midrst_235", an_out, 235);

        // 6. Soak with random handshakes
        soak_done = 0;
        fork
            begin
                for (int k = 0; k < 1500; k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(N_W'($urandom), 1);
                end
                for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(posedge clk);
                soak_done = 1;
            end
            begin
                while (!soak_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        chk("soak_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
